// File: rtl/core_mem_pkg.sv
// ---------------------------------------------------------------------------
// core_mem_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings carried on mem_ram_size
//   - responder FSM state encoding
//   - latched request record
//   - byte-lane mask helper
// ---------------------------------------------------------------------------
package core_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   // Request fields captured at acceptance; the access in flight uses only these.
   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] din;
   } req_t;

   // Byte lanes touched by an access of the given size starting at lane.
   // A half always occupies the lane pair selected by lane[1].
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SZ_BYTE: mask = 4'b0001 << lane;
         SZ_HALF: mask = 4'b0011 << {lane[1], 1'b0};
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/core_dmem_sram.sv
// ---------------------------------------------------------------------------
// core_dmem_sram
// Synchronous DEPTH x 32 word array, single address port.
//   clk    in   core clock
//   we     in   write strobe
//   be     in   byte write enables (bit b enables wdata[8b+7:8b])
//   addr   in   word address, shared by read and write
//   wdata  in   write data
//   rdata  out  registered read data of the word addressed at the last edge
//               (old contents on a same-cycle write)
// ---------------------------------------------------------------------------
module core_dmem_sram #(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // NOTE: the array and its read register have no reset; contents must
   // survive rst_n, and a reset term would stop the array mapping onto RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/core_dmem_resp.sv
// ---------------------------------------------------------------------------
// core_dmem_resp
// Data-memory responder for the MEM stage RAM request port. Accepts one
// load/store at a time, performs it on a byte-enabled word array after
// WAIT_CYCLES extra cycles, and answers with a one-cycle ram_done pulse.
//   clk           in   core clock
//   rst_n         in   asynchronous active-low reset
//   mem_ram_en    in   request valid, held by the initiator until ram_done
//   mem_ram_wen   in   1 = store, 0 = load
//   mem_ram_addr  in   byte address
//   mem_ram_size  in   0 byte, 1 half, 2 word, 3 reserved
//   mem_ram_din   in   store data, right-justified
//   ram_done      out  one-cycle completion pulse
//   ram_dout      out  zero-extended load data, valid with ram_done
//   ram_err       out  misaligned / out-of-range / reserved-size flag
// ---------------------------------------------------------------------------
module core_dmem_resp
   import core_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ram_en,
   input  logic        mem_ram_wen,
   input  logic [31:0] mem_ram_addr,
   input  logic [1:0]  mem_ram_size,
   input  logic [31:0] mem_ram_din,
   output logic        ram_done,
   output logic [31:0] ram_dout,
   output logic        ram_err
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   req_t        req_q,   req_d;
   logic        done_q,  done_d;
   logic        err_q,   err_d;
   logic [31:0] dout_q,  dout_d;

   // ------------------------------------------------------------------
   // Address decode. While idle the array is pre-read at the incoming
   // address so the registered read data is ready by the time the access
   // fires; once accepted, the latched address takes over.
   // ------------------------------------------------------------------
   logic [31:0] sel_addr;
   logic [31:0] off;
   logic [29:0] word_idx;
   logic [1:0]  lane;
   logic        below_base;
   logic        out_of_range;
   logic        size_err;
   logic        acc_err;
   logic        fire;

   logic          sram_we;
   logic [3:0]    sram_be;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;
   logic [31:0]   rd_shift;
   logic [31:0]   load_data;

   always_comb begin
      sel_addr     = (state_q == IDLE) ? mem_ram_addr : req_q.addr;
      off          = sel_addr - BASE_ADDR;
      word_idx     = off[31:2];
      lane         = off[1:0];
      below_base   = (req_q.addr < BASE_ADDR);
      out_of_range = ({2'b00, word_idx} >= DEPTH_W);
   end

   always_comb begin
      size_err = 1'b0;
      case (req_q.size)
         SZ_BYTE: size_err = 1'b0;
         SZ_HALF: size_err = lane[0];
         SZ_WORD: size_err = (lane != 2'b00);
         default: size_err = 1'b1;
      endcase
   end

   assign acc_err = size_err | below_base | out_of_range;
   assign fire    = (state_q == ACCESS) && (cnt_q == 4'd0);

   // Store data is replicated across the word so that whichever lanes the
   // mask enables already hold the right bytes.
   always_comb begin
      sram_wdata = req_q.din;
      case (req_q.size)
         SZ_BYTE: sram_wdata = {4{req_q.din[7:0]}};
         SZ_HALF: sram_wdata = {2{req_q.din[15:0]}};
         default: sram_wdata = req_q.din;
      endcase
   end

   assign sram_we   = fire & req_q.wen & ~acc_err;
   assign sram_be   = lane_mask(req_q.size, lane);
   assign sram_addr = word_idx[AW-1:0];

   // Load extraction: shift the addressed lane down, then zero-extend.
   assign rd_shift = sram_rdata >> {lane, 3'b000};

   always_comb begin
      load_data = sram_rdata;
      case (req_q.size)
         SZ_BYTE: load_data = {24'h0, rd_shift[7:0]};
         SZ_HALF: load_data = {16'h0, rd_shift[15:0]};
         default: load_data = sram_rdata;
      endcase
   end

   core_dmem_sram #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .be    (sram_be),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   // ------------------------------------------------------------------
   // FSM next state and registered response
   // ------------------------------------------------------------------
   // NOTE: every signal assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      dout_d  = 32'h0;

      case (state_q)
         IDLE: begin
            if (mem_ram_en) begin
               req_d.wen  = mem_ram_wen;
               req_d.addr = mem_ram_addr;
               req_d.size = mem_ram_size;
               req_d.din  = mem_ram_din;
               cnt_d      = WAIT_INIT;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               done_d  = 1'b1;
               err_d   = acc_err;
               dout_d  = (!req_q.wen && !acc_err) ? load_data : 32'h0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // The initiator still holds mem_ram_en here; it is not sampled.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values; reset is asynchronous and takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   assign ram_done = done_q;
   assign ram_err  = err_q;
   assign ram_dout = dout_q;

endmodule
